sha1_padder: RTL
================

SHA1_PADDER -- requirements
Module: sha1_padder

Interface
REQ-001 SHALL have parameter BlockWidth, default 512, output block width in bits; only 512 supported.
REQ-002 SHALL have parameter WordWidth, default 32, input word width in bits; only 32 supported.
REQ-003 SHALL have parameter LenWidth, default 64, message bit-length field width; only 64 supported.
REQ-004 SHALL have port clk_i  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid_i  input  1  message word valid.
REQ-007 SHALL have port in_ready_o  output  1  message word accepted when in_valid_i & in_ready_o.
REQ-008 SHALL have port in_data_i  input  32  message word, big-endian, first byte in [31:24].
REQ-009 SHALL have port in_keep_i  input  3  valid byte count 0..4, left-aligned; must be 4 unless in_last_i; 0 only with in_last_i.
REQ-010 SHALL have port in_last_i  input  1  final word of message.
REQ-011 SHALL have port block_valid_o  output  1  padded block available.
REQ-012 SHALL have port block_ready_i  input  1  consumer accepts block when block_valid_o & block_ready_i.
REQ-013 SHALL have port block_o  output  512  block, word 0 at [511:480], word 15 at [31:0].
REQ-014 SHALL have port block_last_o  output  1  block_o is final block of message; valid with block_valid_o.

Function
REQ-015 SHALL implement states FILL and EMIT; in_ready_o = (state==FILL); block_valid_o = (state==EMIT).
REQ-016 FILL: each accepted word SHALL be written at word index idx (4-bit), unused bytes zeroed, idx incremented, bit length incremented by 8*in_keep_i modulo 2^64.
REQ-017 Non-last word accepted at idx==15 SHALL move to EMIT with block_last_o=0 next cycle, idx wrapping to 0.
REQ-018 On accepted last word, 0x80 SHALL be placed at byte in_keep_i of word idx if in_keep_i<4, else at [31:24] of word idx+1.
REQ-019 Pad position p (word holding 0x80) <=13: words after p through 13 zero, words 14/15 = total bit length (high/low, including final word), block_last_o=1, go EMIT.
REQ-020 p in {14,15,16}: remaining words zero, block_last_o=0, extra-block pending set, go EMIT; p==16 also sets 0x80 pending.
REQ-021 EMIT handshake with extra pending SHALL load extra block (word 0 = 0x80000000 if 0x80 pending else 0, words 1..13 zero, 14/15 length), block_last_o=1, stay EMIT.
REQ-022 EMIT handshake with block_last_o=1 SHALL return to FILL, clear idx, length, flags.
REQ-023 EMIT handshake with block_last_o=0 and no extra pending SHALL return to FILL, keeping length.
REQ-024 block_o and block_last_o SHALL be registered and stable while block_valid_o & ~block_ready_i.
REQ-025 Latency: last accepted word to block_valid_o = 1 cycle; back-to-back blocks with no bubble in EMIT.
REQ-026 in_valid_i in EMIT SHALL be ignored (not accepted, no state change).

Reset
REQ-027 On rst_ni low: state FILL, in_ready_o=1, block_valid_o=0, block_o=0, block_last_o=0, idx=0, length=0, pending flags 0.
REQ-028 Reset mid-message or mid-EMIT SHALL discard all partial data immediately.

Configuration
REQ-029 Macro SHA1_PADDER_ABORT_EN defined: input abort_i (1 bit) SHALL exist; abort_i high at a clock edge SHALL force FILL, clear idx/length/flags/block_valid_o, accept no word that cycle, take priority over handshakes.
REQ-030 Without SHA1_PADDER_ABORT_EN: no abort_i port; only rst_ni clears partial messages.

Verification
REQ-031 "abc": one word 0x61626300, keep=3, last -> one block, word0 0x61626380, words1-14 0, word15 0x00000018, last=1.
REQ-032 Empty: keep=0, last -> one block, word0 0x80000000, words1-15 0, last=1.
REQ-033 55 bytes (13 full words + keep=3) -> single block, word13 low byte 0x80, word15 0x000001B8.
REQ-034 56 bytes (14 full words, last keep=4) -> block1 word14 0x80000000, last=0; block2 all zero except word15 0x000001C0, last=1.
REQ-035 64 bytes -> block1 = data, last=0; block2 word0 0x80000000, word15 0x00000200, last=1; block_ready_i held low 5 cycles -> block_o stable, in_ready_o 0.
REQ-036 With SHA1_PADDER_ABORT_EN: abort_i after 7 words, then "abc" -> output identical to REQ-031.

Source files
------------

// File: rtl/sha1_padder.sv
// rtl/sha1_padder.sv - SHA-1 message padder: packs 32-bit big-endian words into 512-bit padded blocks
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   abort_i                       (only with SHA1_PADDER_ABORT_EN) drop the partial message
//   in_valid_i/in_ready_o         message word handshake
//   in_data_i, in_keep_i          word (first byte in [31:24]) and left-aligned valid byte count 0..4
//   in_last_i                     final word of the message
//   block_valid_o/block_ready_i   padded block handshake
//   block_o, block_last_o         512-bit block (word 0 in [511:480]) and final-block flag
//
// Optional feature: define SHA1_PADDER_ABORT_EN to add the abort_i input.

module sha1_padder #(
    parameter int BlockWidth = 512,
    parameter int WordWidth  = 32,
    parameter int LenWidth   = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
`ifdef SHA1_PADDER_ABORT_EN
    input  logic                  abort_i,
`endif
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [WordWidth-1:0]  in_data_i,
    input  logic [2:0]            in_keep_i,
    input  logic                  in_last_i,
    output logic                  block_valid_o,
    input  logic                  block_ready_i,
    output logic [BlockWidth-1:0] block_o,
    output logic                  block_last_o
);

    localparam int NumWords = BlockWidth / WordWidth;

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t                state;
    logic [3:0]            idx;
    logic [LenWidth-1:0]   len;
    logic                  extra_pending;  // a length-only block must follow the current one
    logic                  pad_pending;    // that extra block also carries the 0x80 marker

    logic [WordWidth-1:0]  keep_mask;
    logic [WordWidth-1:0]  pad_byte;
    logic [WordWidth-1:0]  data_word;
    logic [LenWidth-1:0]   len_next;
    logic [4:0]            pad_pos;
    logic [BlockWidth-1:0] fill_block;
    logic [BlockWidth-1:0] ext_block;

    assign in_ready_o    = (state == FILL);
    assign block_valid_o = (state == EMIT);

    always_comb begin
        keep_mask = '0;
        pad_byte  = '0;
        case (in_keep_i)
            3'd0: begin keep_mask = 32'h0000_0000; pad_byte = 32'h8000_0000; end
            3'd1: begin keep_mask = 32'hFF00_0000; pad_byte = 32'h0080_0000; end
            3'd2: begin keep_mask = 32'hFFFF_0000; pad_byte = 32'h0000_8000; end
            3'd3: begin keep_mask = 32'hFFFF_FF00; pad_byte = 32'h0000_0080; end
            default: begin keep_mask = 32'hFFFF_FFFF; pad_byte = 32'h0000_0000; end
        endcase

        data_word = in_data_i & keep_mask;
        len_next  = len + LenWidth'({in_keep_i, 3'b000});
        // A full final word pushes the 0x80 marker into the next word slot;
        // pad_pos == 16 means it spills past this block entirely.
        pad_pos   = (in_keep_i >= 3'd4) ? ({1'b0, idx} + 5'd1) : {1'b0, idx};

        fill_block = block_o;
        for (int w = 0; w < NumWords; w++) begin
            if (4'(w) == idx) begin
                fill_block[BlockWidth-1-WordWidth*w -: WordWidth] =
                    in_last_i ? (data_word | pad_byte) : data_word;
            end else if (in_last_i && (4'(w) > idx)) begin
                fill_block[BlockWidth-1-WordWidth*w -: WordWidth] =
                    (5'(w) == pad_pos) ? 32'h8000_0000 : 32'h0000_0000;
            end
        end
        if (in_last_i && (pad_pos <= 5'd13)) begin
            fill_block[LenWidth-1:0] = len_next;
        end

        ext_block = '0;
        ext_block[BlockWidth-1 -: WordWidth] = pad_pending ? 32'h8000_0000 : 32'h0000_0000;
        ext_block[LenWidth-1:0] = len;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= FILL;
            idx           <= '0;
            len           <= '0;
            extra_pending <= 1'b0;
            pad_pending   <= 1'b0;
            block_o       <= '0;
            block_last_o  <= 1'b0;
        end else begin
`ifdef SHA1_PADDER_ABORT_EN
            if (abort_i) begin
                state         <= FILL;
                idx           <= '0;
                len           <= '0;
                extra_pending <= 1'b0;
                pad_pending   <= 1'b0;
                block_last_o  <= 1'b0;
            end else
`endif
            begin
                case (state)
                    FILL: begin
                        if (in_valid_i) begin
                            block_o <= fill_block;
                            len     <= len_next;
                            if (in_last_i) begin
                                idx   <= '0;
                                state <= EMIT;
                                if (pad_pos <= 5'd13) begin
                                    block_last_o <= 1'b1;
                                end else begin
                                    block_last_o  <= 1'b0;
                                    extra_pending <= 1'b1;
                                    pad_pending   <= (pad_pos == 5'd16);
                                end
                            end else begin
                                idx <= idx + 4'd1;
                                if (idx == 4'd15) begin
                                    state        <= EMIT;
                                    block_last_o <= 1'b0;
                                end
                            end
                        end
                    end
                    EMIT: begin
                        if (block_ready_i) begin
                            if (extra_pending) begin
                                block_o       <= ext_block;
                                block_last_o  <= 1'b1;
                                extra_pending <= 1'b0;
                                pad_pending   <= 1'b0;
                            end else if (block_last_o) begin
                                state        <= FILL;
                                idx          <= '0;
                                len          <= '0;
                                block_last_o <= 1'b0;
                            end else begin
                                state <= FILL;
                            end
                        end
                    end
                    default: state <= FILL;
                endcase
            end
        end
    end

endmodule
